// File: rtl/minbal_sched.sv
// Round-robin front end sharing one chunked ones/zeros counter between N_REQ requesters.
// Optional early exit on threshold satisfaction is enabled by defining MINBAL_EARLY_EXIT_EN.
module minbal_sched #(
  parameter int N_REQ   = 4,
  parameter int DATA_W  = 32,
  parameter int CHUNK_W = 8,
  parameter int CNT_W   = $clog2(DATA_W + 1),
  parameter int ID_W    = $clog2(N_REQ)
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ*DATA_W-1:0]   req_value,
  output logic [N_REQ-1:0]          req_ready,
  input  logic [CNT_W-1:0]          thr_ones,
  input  logic [CNT_W-1:0]          thr_zeros,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic                      res_pass,
  output logic [ID_W-1:0]           res_id,
  output logic [CNT_W-1:0]          res_ones,
  output logic [CNT_W-1:0]          res_zeros,
  output logic                      busy
);

  localparam int N_CHUNK = DATA_W / CHUNK_W;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  function automatic logic [CNT_W-1:0] popcount(input logic [CHUNK_W-1:0] v);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < CHUNK_W; i++) begin
      c = c + CNT_W'(v[i]);
    end
    return c;
  endfunction

  state_t            state_r;
  logic [ID_W-1:0]   rr_ptr_r;
  logic [ID_W-1:0]   id_r;
  logic [DATA_W-1:0] word_r;
  logic [CNT_W-1:0]  thr_ones_r;
  logic [CNT_W-1:0]  thr_zeros_r;
  logic [CNT_W-1:0]  ones_r;
  logic [CNT_W-1:0]  zeros_r;
  logic [CNT_W-1:0]  chunk_cnt_r;

  logic              grant_found_s;
  logic [ID_W-1:0]   grant_id_s;
  logic [ID_W-1:0]   cand_s;
  logic              hit_s;
  logic [N_REQ-1:0]  grant_oh_s;
  logic [DATA_W-1:0] grant_word_s;
  logic              accept_s;
  logic [CNT_W-1:0]  chunk_ones_s;
  logic [CNT_W-1:0]  ones_nxt_s;
  logic [CNT_W-1:0]  zeros_nxt_s;
  logic              last_chunk_s;
  logic              pass_nxt_s;
  logic              exit_s;

  // Search for the first valid requester at or after the round-robin pointer.
  always_comb begin
    grant_found_s = 1'b0;
    grant_id_s    = '0;
    cand_s        = '0;
    hit_s         = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      cand_s        = ID_W'((int'(rr_ptr_r) + k) % N_REQ);
      hit_s         = req_valid[cand_s] & ~grant_found_s;
      grant_id_s    = hit_s ? cand_s : grant_id_s;
      grant_found_s = grant_found_s | hit_s;
    end
  end

  // Select the granted requester's word with constant slice bases.
  always_comb begin
    grant_word_s = '0;
    for (int k = 0; k < N_REQ; k++) begin
      grant_word_s = (grant_id_s == ID_W'(k)) ? req_value[k*DATA_W +: DATA_W] : grant_word_s;
    end
  end

  assign grant_oh_s = grant_found_s ? ({{(N_REQ-1){1'b0}}, 1'b1} << grant_id_s) : '0;
  // Gating with reset_n keeps the grant low while reset is held even with valids pending.
  assign req_ready  = ((state_r == ST_IDLE) && reset_n) ? grant_oh_s : '0;
  assign accept_s   = (state_r == ST_IDLE) && grant_found_s;
  assign busy       = (state_r != ST_IDLE);

  // Per-chunk accumulation and the exit decision for the COUNT state.
  always_comb begin
    chunk_ones_s = popcount(word_r[CHUNK_W-1:0]);
    ones_nxt_s   = ones_r + chunk_ones_s;
    zeros_nxt_s  = zeros_r + (CNT_W'(CHUNK_W) - chunk_ones_s);
    last_chunk_s = (chunk_cnt_r == CNT_W'(N_CHUNK - 1));
    pass_nxt_s   = (ones_nxt_s >= thr_ones_r) && (zeros_nxt_s >= thr_zeros_r);
`ifdef MINBAL_EARLY_EXIT_EN
    exit_s       = last_chunk_s | pass_nxt_s;
`else
    exit_s       = last_chunk_s;
`endif
  end

  // Scheduler FSM with registered result outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= ST_IDLE;
      rr_ptr_r    <= '0;
      id_r        <= '0;
      word_r      <= '0;
      thr_ones_r  <= '0;
      thr_zeros_r <= '0;
      ones_r      <= '0;
      zeros_r     <= '0;
      chunk_cnt_r <= '0;
      res_valid   <= 1'b0;
      res_pass    <= 1'b0;
      res_id      <= '0;
      res_ones    <= '0;
      res_zeros   <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            word_r      <= grant_word_s;
            id_r        <= grant_id_s;
            thr_ones_r  <= thr_ones;
            thr_zeros_r <= thr_zeros;
            ones_r      <= '0;
            zeros_r     <= '0;
            chunk_cnt_r <= '0;
            rr_ptr_r    <= (grant_id_s == ID_W'(N_REQ - 1)) ? '0 : grant_id_s + 1'b1;
            state_r     <= ST_COUNT;
          end else begin
            state_r     <= ST_IDLE;
          end
        end
        ST_COUNT: begin
          ones_r      <= ones_nxt_s;
          zeros_r     <= zeros_nxt_s;
          word_r      <= word_r >> CHUNK_W;
          chunk_cnt_r <= chunk_cnt_r + 1'b1;
          if (exit_s) begin
            res_valid <= 1'b1;
            res_pass  <= pass_nxt_s;
            res_id    <= id_r;
            res_ones  <= ones_nxt_s;
            res_zeros <= zeros_nxt_s;
            state_r   <= ST_DONE;
          end else begin
            state_r   <= ST_COUNT;
          end
        end
        ST_DONE: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state_r   <= ST_IDLE;
          end else begin
            state_r   <= ST_DONE;
          end
        end
        default: begin
          res_valid <= 1'b0;
          state_r   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
